chain_dispatch_unit: RTL and testbench
======================================

// Module: chain_dispatch_unit
// PURPOSE
//  Upstream transmitter for the per-chain vector stream (valid/eof/chainId/vector) consumed by the filter-reduce stage.
//  - Accepts one N-wide trace vector per handshake.
//  - Re-emits it once per active chain on consecutive cycles, tagging each copy with chainId 0..k-1.
//  - The active chain count k is firmware-configurable over the configId/configData bus.
//  - Sits between the trace input buffer and the filter-reduce stage.
// PARAMETERS
//  N                   8   vector lanes
//  DATA_WIDTH          32  bits per lane
//  MAX_CHAINS          4   max chains; chainId width CW=$clog2(MAX_CHAINS)
//  PERSONAL_CONFIG_ID  0   configId value addressing this block
//  INITIAL_NUM_CHAINS  1   chain count k after reset (1..MAX_CHAINS)
// PORTS
//  clk          in   1              clock, all logic on posedge
//  reset        in   1              synchronous, active-high
//  tracing      in   1              global trace enable
//  valid_in     in   1              input vector valid
//  eof_in       in   1              input vector is end-of-frame
//  vector_in    in   DATA_WIDTH x N input vector
//  ready_out    out  1              block can accept (combinational)
//  configId     in   8              config target id
//  configData   in   8              config payload: requested chain count
//  vector_out   out  DATA_WIDTH x N replicated vector (registered)
//  chainId_out  out  CW             chain tag of this copy
//  valid_out    out  1              output copy valid
//  eof_out      out  1              copy belongs to an eof vector
// BEHAVIOUR
//  Reset values:
//  - valid_out=0, eof_out=0, chainId_out=0, vector_out=all zero.
//  - State IDLE; num_chains=INITIAL_NUM_CHAINS.
//  Config:
//  - configId==PERSONAL_CONFIG_ID updates num_chains on the next edge.
//  - configData==0 clamps to 1; configData>MAX_CHAINS clamps to MAX_CHAINS.
//  - Any vector already accepted keeps the count latched at its accept.
//  FSM:
//  - IDLE: ready_out=tracing.
//  - EMIT: ready_out = tracing && (cnt==k_lat-1).
//  Accept = valid_in && ready_out. On accept:
//  - Latch vector_in, eof_in, k_lat=num_chains; cnt=0; go to EMIT.
//  - The first copy appears on outputs at the next edge (latency 1).
//  In EMIT, each cycle:
//  - Drive valid_out=1, chainId_out=cnt, and the latched vector/eof.
//  - Increment cnt.
//  - After copy k_lat-1: go to EMIT if another accept occurred that cycle, otherwise IDLE.
//  - Back-to-back vectors produce no bubble.
//  Output rules:
//  - No downstream backpressure: exactly one copy per cycle while in EMIT.
//  - eof_out is asserted on every copy of an eof vector; deasserted otherwise.
//  - k_lat=1 gives pure 1-cycle passthrough; ready_out stays high while tracing.
//  tracing deasserted:
//  - ready_out=0 and valid_out=0 on the next edge.
//  - Remaining copies of the in-flight vector are dropped; state goes to IDLE.
//  - vector_out/chainId_out hold their last values.
//  Reset mid-emission: the in-flight vector is discarded and all reset values apply on the next edge.
//  Simultaneous config write and accept: the accepted vector uses the old num_chains.
//  valid_out is never high in IDLE; the chainId_out sequence per vector is always 0,1,..,k_lat-1 with no gaps.
// TESTING
//  1. num=3, one vector V=[1..8] at t:
//     - t+1..t+3: valid_out=1, chainId 0,1,2, vector_out=V.
//     - ready_out low at t+1,t+2, high at t+3.
//     - t+4: valid_out=0.
//  2. num=2, valid_in held with A then B:
//     - Outputs A/0, A/1, B/0, B/1 on 4 consecutive cycles, no bubble.
//  3. Clamping:
//     - configData=0: 1 copy per vector, ready_out=1 continuously.
//     - configData=7 (MAX_CHAINS=4): 4 copies, chainId 0..3.
//  4. Config 4->2 written during A's copy 1:
//     - A emits 4 copies.
//     - Next vector B emits 2.
//  5. eof vector, num=2 -> eof_out=1 on both copies; a following non-eof vector -> eof_out=0.
//  6. Abort cases:
//     - tracing dropped after copy 0 of 3 -> valid_out=0 next cycle; vector not resumed.
//     - reset mid-emission -> all outputs at reset values; num_chains=INITIAL_NUM_CHAINS.

Source files
------------

// File: rtl/chain_dispatch_if.sv
// chain_dispatch_if: trace vector input, per-chain copies output and firmware config bus
interface chain_dispatch_if #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  logic tracing;
  logic valid_in;
  logic eof_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic ready_out;
  logic [7:0] configId;
  logic [7:0] configData;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [CW-1:0] chainId_out;
  logic valid_out;
  logic eof_out;
  modport master (
    output tracing, valid_in, eof_in, vector_in, configId, configData,
    input ready_out, vector_out, chainId_out, valid_out, eof_out
  );
  modport slave (
    input tracing, valid_in, eof_in, vector_in, configId, configData,
    output ready_out, vector_out, chainId_out, valid_out, eof_out
  );
endinterface

// File: rtl/chain_dispatch_unit.sv
// chain_dispatch_unit: re-emits each accepted trace vector once per active chain, tagged 0..k-1
module chain_dispatch_unit #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int INITIAL_NUM_CHAINS = 1
) (
  input logic clk,
  input logic reset,
  chain_dispatch_if.slave bus
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int KW = $clog2(MAX_CHAINS + 1);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] num_chains, k_lat, cfg_k;
  logic [CW-1:0] cnt;
  logic [N-1:0][DATA_WIDTH-1:0] vec_q;
  logic valid_q, eof_q, last, ready, accept, adv, cfg_hit;
  assign cfg_hit = bus.configId == 8'(PERSONAL_CONFIG_ID);
  assign cfg_k = (bus.configData == 8'd0) ? KW'(1) :
                 (bus.configData > 8'(MAX_CHAINS)) ? KW'(MAX_CHAINS) : KW'(bus.configData);
  always_comb begin
    last = KW'(cnt) == k_lat - KW'(1);
    ready = bus.tracing && (state_q == IDLE || last);
    accept = bus.valid_in && ready;
    adv = state_q == EMIT && bus.tracing && !last;
    state_d = accept ? EMIT : (!bus.tracing || last) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_chains <= KW'(INITIAL_NUM_CHAINS);
      k_lat <= KW'(INITIAL_NUM_CHAINS);
      cnt <= '0;
      vec_q <= '0;
      valid_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_hit) num_chains <= cfg_k;
      if (accept) begin
        k_lat <= num_chains;
        cnt <= '0;
        vec_q <= bus.vector_in;
      end else if (adv) cnt <= cnt + CW'(1);
      valid_q <= accept || adv;
      eof_q <= accept ? bus.eof_in : eof_q & adv;
    end
  end
  assign bus.ready_out = ready;
  assign bus.valid_out = valid_q;
  assign bus.eof_out = eof_q;
  assign bus.chainId_out = cnt;
  assign bus.vector_out = vec_q;
endmodule

// File: tb/tb_chain_dispatch_unit.sv
// tb_chain_dispatch_unit: directed vectors with hand-computed expectations for chain_dispatch_unit
module tb_chain_dispatch_unit;
  typedef logic [7:0][31:0] vec_t;
  logic clk, reset;
  int n_cmp, n_bad;
  chain_dispatch_if #(.N(8), .DATA_WIDTH(32), .MAX_CHAINS(4)) bus ();
  chain_dispatch_unit #(.N(8), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0),
                        .INITIAL_NUM_CHAINS(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mkvec(input int b);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = 32'(b + i);
    return v;
  endfunction
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [7:0] d);
    bus.configId = 8'd0;
    bus.configData = d;
    cyc();
    bus.configId = 8'hff;
  endtask
  task automatic copy(input string tag, input int id, input vec_t v);
    check({tag, ".valid"}, 256'(bus.valid_out), 256'(1));
    check({tag, ".id"}, 256'(bus.chainId_out), 256'(id));
    check({tag, ".vec"}, bus.vector_out, v);
  endtask
  task automatic rdy(input string tag, input logic e);
    #1;
    check({tag, ".ready"}, 256'(bus.ready_out), 256'(e));
  endtask
  task automatic idle(input string tag);
    check({tag, ".valid"}, 256'(bus.valid_out), 256'(0));
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.tracing = 1'b1;
    bus.valid_in = 1'b0;
    bus.eof_in = 1'b0;
    bus.vector_in = '0;
    bus.configId = 8'hff;
    bus.configData = 8'd0;
    cyc();
    cyc();
    idle("rst");
    check("rst.eof", 256'(bus.eof_out), 256'(0));
    check("rst.id", 256'(bus.chainId_out), 256'(0));
    check("rst.vec", bus.vector_out, 256'(0));
    reset = 1'b0;
    rdy("rst", 1'b1);
    // three copies of one vector, ready only on the last
    cfg(8'd3);
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(1);
    rdy("t1.t", 1'b1);
    cyc();
    bus.valid_in = 1'b0;
    copy("t1.c0", 0, mkvec(1));
    rdy("t1.c0", 1'b0);
    cyc();
    copy("t1.c1", 1, mkvec(1));
    rdy("t1.c1", 1'b0);
    cyc();
    copy("t1.c2", 2, mkvec(1));
    rdy("t1.c2", 1'b1);
    cyc();
    idle("t1.end");
    // back-to-back A then B with two chains
    cfg(8'd2);
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'h100);
    cyc();
    copy("t2.a0", 0, mkvec(16'h100));
    bus.vector_in = mkvec(16'h200);
    cyc();
    copy("t2.a1", 1, mkvec(16'h100));
    cyc();
    copy("t2.b0", 0, mkvec(16'h200));
    bus.valid_in = 1'b0;
    cyc();
    copy("t2.b1", 1, mkvec(16'h200));
    cyc();
    idle("t2.end");
    // configData 0 clamps to one copy
    cfg(8'd0);
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'h300);
    rdy("t3a.t", 1'b1);
    cyc();
    copy("t3a.c", 0, mkvec(16'h300));
    bus.vector_in = mkvec(16'h400);
    rdy("t3a.c", 1'b1);
    cyc();
    copy("t3a.d", 0, mkvec(16'h400));
    rdy("t3a.d", 1'b1);
    bus.valid_in = 1'b0;
    cyc();
    idle("t3a.end");
    // configData 7 clamps to four copies
    cfg(8'd7);
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'h500);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.valid_in = 1'b0;
      copy($sformatf("t3b.c%0d", i), i, mkvec(16'h500));
    end
    cyc();
    idle("t3b.end");
    // count change during emission applies to the next vector only
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'h600);
    cyc();
    bus.valid_in = 1'b0;
    copy("t4.a0", 0, mkvec(16'h600));
    cyc();
    copy("t4.a1", 1, mkvec(16'h600));
    bus.configId = 8'd0;
    bus.configData = 8'd2;
    cyc();
    bus.configId = 8'hff;
    copy("t4.a2", 2, mkvec(16'h600));
    cyc();
    copy("t4.a3", 3, mkvec(16'h600));
    cyc();
    idle("t4.aend");
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'h700);
    cyc();
    bus.valid_in = 1'b0;
    copy("t4.b0", 0, mkvec(16'h700));
    cyc();
    copy("t4.b1", 1, mkvec(16'h700));
    cyc();
    idle("t4.bend");
    // eof vector followed by a plain one
    bus.valid_in = 1'b1;
    bus.eof_in = 1'b1;
    bus.vector_in = mkvec(16'h800);
    cyc();
    check("t5.h0.eof", 256'(bus.eof_out), 256'(1));
    bus.eof_in = 1'b0;
    bus.vector_in = mkvec(16'h900);
    cyc();
    copy("t5.h1", 1, mkvec(16'h800));
    check("t5.h1.eof", 256'(bus.eof_out), 256'(1));
    cyc();
    copy("t5.i0", 0, mkvec(16'h900));
    check("t5.i0.eof", 256'(bus.eof_out), 256'(0));
    bus.valid_in = 1'b0;
    cyc();
    check("t5.i1.eof", 256'(bus.eof_out), 256'(0));
    cyc();
    // tracing dropped after copy 0 of 3
    cfg(8'd3);
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'ha00);
    cyc();
    bus.valid_in = 1'b0;
    copy("t6a.c0", 0, mkvec(16'ha00));
    bus.tracing = 1'b0;
    rdy("t6a.off", 1'b0);
    cyc();
    idle("t6a.drop");
    check("t6a.hold.id", 256'(bus.chainId_out), 256'(0));
    check("t6a.hold.vec", bus.vector_out, mkvec(16'ha00));
    bus.tracing = 1'b1;
    cyc();
    idle("t6a.noresume");
    rdy("t6a.on", 1'b1);
    // reset mid-emission
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'hb00);
    cyc();
    bus.valid_in = 1'b0;
    copy("t6b.c0", 0, mkvec(16'hb00));
    cyc();
    copy("t6b.c1", 1, mkvec(16'hb00));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle("t6b.rst");
    check("t6b.rst.id", 256'(bus.chainId_out), 256'(0));
    check("t6b.rst.vec", bus.vector_out, 256'(0));
    // config write on the accept edge: this vector keeps the reset count of one
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'hc00);
    bus.configId = 8'd0;
    bus.configData = 8'd3;
    cyc();
    bus.configId = 8'hff;
    bus.valid_in = 1'b0;
    copy("t7.m0", 0, mkvec(16'hc00));
    rdy("t7.m0", 1'b1);
    cyc();
    idle("t7.mend");
    bus.valid_in = 1'b1;
    bus.vector_in = mkvec(16'hd00);
    cyc();
    bus.valid_in = 1'b0;
    copy("t7.n0", 0, mkvec(16'hd00));
    rdy("t7.n0", 1'b0);
    cyc();
    cyc();
    copy("t7.n2", 2, mkvec(16'hd00));
    cyc();
    idle("t7.nend");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
